// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache request/return protocol: in-order
// request FIFO, fixed (or LFSR-jittered with WT_MEM_RESP_RAND_LAT_EN) latency, 64-bit word store.
module wt_mem_responder #(
  parameter int unsigned TidWidth  = 2,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned MemWords  = 1024,
  parameter int unsigned Latency   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_data_req_i,
  output logic                mem_data_ack_o,
  input  logic                mem_rtype_i,
  input  logic                mem_nc_i,
  input  logic [2:0]          mem_size_i,
  input  logic [TidWidth-1:0] mem_tid_i,
  input  logic [63:0]         mem_paddr_i,
  input  logic [63:0]         mem_wdata_i,
  output logic                mem_rtrn_vld_o,
  output logic                mem_rtrn_rtype_o,
  output logic [TidWidth-1:0] mem_rtrn_tid_o,
  output logic [127:0]        mem_rtrn_data_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(Latency + 8) + 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FifoDepth);

  typedef struct packed {
    logic                rtype;
    logic                nc;
    logic [2:0]          size;
    logic [TidWidth-1:0] tid;
    logic [63:0]         paddr;
    logic [63:0]         wdata;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  function automatic logic [7:0] byte_en(input logic [2:0] size, input logic [2:0] off);
    logic [15:0] mask;
    mask = (16'd1 << (4'd1 << size)) - 16'd1;
    mask = mask << off;
    return mask[7:0];
  endfunction

  function automatic logic [127:0] rtrn_line(input logic rtype, input logic nc,
                                             input logic [63:0] word, input logic [63:0] lo,
                                             input logic [63:0] hi);
    if (rtype)   return '0;
    else if (nc) return {word, word};
    else         return {hi, lo};
  endfunction

  req_t            fifo_q [FifoDepth];
  req_t            req_p0;
  req_t            exe_p1;
  logic [63:0]     mem [MemWords];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW:0]   fill, fill_nxt;
  logic            fifo_full, fifo_empty, push, pop;
  state_t          state;
  logic [CntW-1:0] cnt, cnt_init;
  logic [IdxW-1:0] word_idx, line_lo, line_hi;
  logic [7:0]      st_be;
  logic [127:0]    rtrn_data;
  logic            unused_paddr_hi;

  assign req_p0 = '{rtype: mem_rtype_i, nc: mem_nc_i, size: mem_size_i, tid: mem_tid_i,
                    paddr: mem_paddr_i, wdata: mem_wdata_i};

  assign fifo_full      = (fill == FullCnt);
  assign fifo_empty     = (fill == '0);
  assign mem_data_ack_o = mem_data_req_i & ~fifo_full;
  assign push           = mem_data_ack_o;
  assign pop            = ~fifo_empty & ((state == ST_IDLE) | (state == ST_RESP));
  assign fill_nxt       = fill + (PtrW + 1)'(push) - (PtrW + 1)'(pop);

  // Upper address bits alias: only the word index selects storage.
  assign word_idx        = exe_p1.paddr[3 +: IdxW];
  assign line_lo         = word_idx & ~IdxW'(1);
  assign line_hi         = word_idx | IdxW'(1);
  assign st_be           = byte_en(exe_p1.size, exe_p1.paddr[2:0]);
  assign rtrn_data       = rtrn_line(exe_p1.rtype, exe_p1.nc, mem[word_idx], mem[line_lo],
                                     mem[line_hi]);
  assign unused_paddr_hi = ^exe_p1.paddr[63:3+IdxW];

`ifdef WT_MEM_RESP_RAND_LAT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_init = CntW'(Latency - 1) + CntW'(lfsr[2:0]);
`else
  assign cnt_init = CntW'(Latency - 1);
`endif

  // Stage p0 -> p1: FIFO storage and execution register carry data only, no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= req_p0;
    if (pop)  exe_p1 <= fifo_q[rd_ptr];
  end

  // Stores commit in the RESP cycle so any later queued load observes them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == ST_RESP && exe_p1.rtype) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= exe_p1.wdata[8*b +: 8];
      end
    end
  end

  // Stage p1 -> return: control FSM and registered return packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill             <= '0;
      busy_o           <= 1'b0;
      mem_rtrn_vld_o   <= 1'b0;
      mem_rtrn_rtype_o <= 1'b0;
      mem_rtrn_tid_o   <= '0;
      mem_rtrn_data_o  <= '0;
    end else begin
      fill           <= fill_nxt;
      busy_o         <= (fill_nxt != '0) | pop | (state == ST_WAIT);
      mem_rtrn_vld_o <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state <= ST_WAIT;
            cnt   <= cnt_init;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state            <= ST_RESP;
            mem_rtrn_vld_o   <= 1'b1;
            mem_rtrn_rtype_o <= exe_p1.rtype;
            mem_rtrn_tid_o   <= exe_p1.tid;
            mem_rtrn_data_o  <= rtrn_data;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        ST_RESP: begin
          if (pop) begin
            state <= ST_WAIT;
            cnt   <= cnt_init;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
